// File: rtl/schmitt_scan_ctrl.sv
// Shares one Schmitt threshold detector across NCHAN channels by time-multiplexing it.
// Each channel visit takes SETTLE+2 cycles (select, settle, sample). Events appear one cycle after SAMPLE.
// The single-entry event register drops a new event while an unaccepted one is held, and flags overrun.
module schmitt_scan_ctrl #(
  parameter int NCHAN  = 4,
  parameter int CHW    = 2,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [CHW-1:0]   mux_sel,
  output logic             thr_hi,
  input  logic             cmp_in,
  output logic [NCHAN-1:0] state_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CHW-1:0]   evt_chan,
  output logic             evt_level,
  output logic             overrun,
  input  logic             ovr_clr
);

  // The counter must hold SETTLE-1.
  localparam int CNTW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CHW-1:0]  ch_q;
  logic [CHW-1:0]  ch_next;
  logic [CNTW-1:0] cnt_q;
  logic            sync1;
  logic            sync2;
  logic            cur_level;
  logic            in_select;
  logic            in_settle;
  logic            in_sample;
  logic            raise;
  logic            accept;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= cmp_in;
      sync2 <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d   = state_q;
    in_select = 1'b0;
    in_settle = 1'b0;
    in_sample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        in_select = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        in_settle = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // The sample always completes; enable only decides whether to continue.
        in_sample = 1'b1;
        state_d   = enable ? ST_SELECT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Hysteresis decision: a change only when the synchronized comparator disagrees with the stored level.
  always_comb begin
    cur_level = state_out[ch_q];
    raise     = in_sample && (sync2 != cur_level);
    accept    = evt_valid && evt_ready;
    ch_next   = (ch_q == CHW'(NCHAN - 1)) ? '0 : ch_q + 1'b1;
  end

  // Channel index advances after each sample and is kept across IDLE so a re-enable resumes the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q <= '0;
    end else if (in_sample) begin
      ch_q <= ch_next;
    end
  end

  // Settle counter: loaded in SELECT, counts down to zero in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (in_select) begin
      cnt_q <= CNTW'(SETTLE - 1);
    end else if (in_settle && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Analog mux and threshold select; registered once per channel and held otherwise, including IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_sel <= '0;
      thr_hi  <= 1'b0;
    end else if (in_select) begin
      mux_sel <= ch_q;
      thr_hi  <= ~state_out[ch_q];
    end
  end

  // Per-channel hysteresis level, at most one bit updated per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
    end else if (raise) begin
      state_out[ch_q] <= sync2;
    end
  end

  // Single-entry event register; a slot being accepted this cycle can take the new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_level <= 1'b0;
    end else if (raise && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_chan  <= ch_q;
      evt_level <= sync2;
    end else if (accept) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new loss in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (raise && evt_valid && !evt_ready) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_schmitt_scan_ctrl.sv
// Directed bench for schmitt_scan_ctrl (NCHAN=4, SETTLE=8, channel period 10 cycles).
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Visit v of the scan starts when mux_sel has just taken its new value.
module tb_schmitt_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mux_sel;
  logic       thr_hi;
  logic       cmp_in;
  logic [3:0] state_out;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic       evt_level;
  logic       overrun;
  logic       ovr_clr;

  int passed = 0;
  int total  = 0;

  schmitt_scan_ctrl #(.NCHAN(4), .CHW(2), .SETTLE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mux_sel   (mux_sel),
    .thr_hi    (thr_hi),
    .cmp_in    (cmp_in),
    .state_out (state_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_level (evt_level),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // From the start of a visit to the cycle after its SAMPLE edge.
  task automatic visit_to_sample(input logic cmp);
    cmp_in = cmp;
    tick(9);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cmp_in    = 1'b0;
    evt_ready = 1'b1;
    ovr_clr   = 1'b0;
    tick(3);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_thr_hi", thr_hi, 0);
    chk("rst_state_out", state_out, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_overrun", overrun, 0);

    // Release reset with enable high: IDLE, SELECT, then channel 0 on the mux.
    enable = 1'b1;
    rst    = 1'b0;
    tick(2);
    chk("start_mux_sel", mux_sel, 0);
    chk("start_thr_hi", thr_hi, 1);

    // Visits 0..3: comparator low, no events, mux steps every 10 cycles.
    for (int v = 0; v < 4; v++) begin
      visit_to_sample(1'b0);
      chk("idle_scan_evt_valid", evt_valid, 0);
      chk("idle_scan_state", state_out, 0);
      tick(1);
      chk("idle_scan_mux_sel", mux_sel, (v + 1) % 4);
      chk("idle_scan_thr_hi", thr_hi, 1);
    end

    // Visits 4..7: comparator high only on channel 2.
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b0);
    tick(1);
    chk("v6_mux_sel", mux_sel, 2);
    visit_to_sample(1'b1);
    chk("rise2_state", state_out, 4'b0100);
    chk("rise2_evt_valid", evt_valid, 1);
    chk("rise2_evt_chan", evt_chan, 2);
    chk("rise2_evt_level", evt_level, 1);
    tick(1);
    chk("rise2_accepted", evt_valid, 0);
    visit_to_sample(1'b0);
    chk("v7_no_evt", evt_valid, 0);
    tick(1);

    // Visits 8..11: channel 2 revisited with comparator still high.
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b0);
    tick(1);
    chk("v10_mux_sel", mux_sel, 2);
    chk("v10_thr_hi_reset_level", thr_hi, 0);
    visit_to_sample(1'b1);
    chk("hold2_no_evt", evt_valid, 0);
    chk("hold2_state", state_out, 4'b0100);
    tick(1);
    visit_to_sample(1'b0);
    tick(1);

    // Visits 12..14: channel 2 falls.
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b0);
    chk("fall2_state", state_out, 0);
    chk("fall2_evt_valid", evt_valid, 1);
    chk("fall2_evt_chan", evt_chan, 2);
    chk("fall2_evt_level", evt_level, 0);
    tick(1);

    // Visits 15..19: consumer stalled; channel 1 then channel 3 rise.
    visit_to_sample(1'b0);
    tick(1);
    evt_ready = 1'b0;
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b1);
    chk("rise1_evt_valid", evt_valid, 1);
    chk("rise1_evt_chan", evt_chan, 1);
    chk("rise1_overrun", overrun, 0);
    tick(1);
    visit_to_sample(1'b0);
    tick(1);
    visit_to_sample(1'b1);
    chk("ovr_state", state_out, 4'b1010);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_evt_valid", evt_valid, 1);
    chk("ovr_evt_chan_held", evt_chan, 1);
    chk("ovr_evt_level_held", evt_level, 1);

    // One-cycle ready pulse accepts the held event; then clear overrun.
    cmp_in    = 1'b0;
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("drain_evt_valid", evt_valid, 0);
    chk("drain_overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("clr_overrun", overrun, 0);
    tick(8);
    chk("v20_no_evt", evt_valid, 0);
    tick(1);
    chk("v21_mux_sel", mux_sel, 1);
    chk("v21_thr_hi", thr_hi, 0);

    // Visit 21: drop enable during SETTLE of channel 1; its sample still happens.
    cmp_in = 1'b0;
    tick(3);
    enable = 1'b0;
    tick(6);
    chk("late_sample_state", state_out, 4'b1000);
    chk("late_sample_evt_valid", evt_valid, 1);
    chk("late_sample_evt_chan", evt_chan, 1);
    chk("late_sample_evt_level", evt_level, 0);
    tick(5);
    chk("idle_mux_hold", mux_sel, 1);
    chk("idle_thr_hold", thr_hi, 0);

    // Re-enable resumes at channel 2.
    enable = 1'b1;
    tick(2);
    chk("resume_mux_sel", mux_sel, 2);
    chk("resume_thr_hi", thr_hi, 1);

    // Reset in the middle of SETTLE with an event pending.
    tick(3);
    chk("pre_rst_evt_valid", evt_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_mux_sel", mux_sel, 0);
    chk("async_rst_thr_hi", thr_hi, 0);
    chk("async_rst_state", state_out, 0);
    chk("async_rst_evt_valid", evt_valid, 0);
    chk("async_rst_evt_chan", evt_chan, 0);
    chk("async_rst_overrun", overrun, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("restart_mux_sel", mux_sel, 0);
    chk("restart_thr_hi", thr_hi, 1);
    tick(10);
    chk("restart_next_mux_sel", mux_sel, 1);
    chk("restart_no_evt", evt_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
